// File: rtl/bp_common_pkg.sv
// Shared definitions for the rolly-FIFO issue controller: FSM state encoding
// and the width of the optional performance counters.
package bp_common_pkg;

    typedef enum logic [0:0] {
        e_rolly_run       = 1'b0,
        e_rolly_flush_clr = 1'b1
    } bp_rolly_issue_state_e;

    localparam int perf_cnt_width_gp = 32;

endpackage

// File: rtl/bp_rolly_issue_ctrl_if.sv
// Issue-side valid/ready channel between the rolly issue controller (master)
// and the issue pipeline (slave).
interface bp_rolly_issue_ctrl_if #(
    parameter int width_p = 64
);
    logic [width_p-1:0] data_o;
    logic               v_o;
    logic               ready_i;

    modport master (output data_o, output v_o, input ready_i);
    modport slave  (input data_o, input v_o, output ready_i);
endinterface

// File: rtl/bp_rolly_issue_skid.sv
// One-entry output register with valid/ready and a synchronous invalidate.
// Invalidate wins over load; a handshake without a new load drops valid.
module bp_rolly_issue_skid #(
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               load_i,
    input  logic [width_p-1:0] data_i,
    input  logic               inval_i,
    input  logic               ready_i,
    output logic [width_p-1:0] data_o,
    output logic               v_o
);

    logic               v_q, v_d;
    logic [width_p-1:0] data_q, data_d;

    // Next-state for the held entry and its valid bit
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (inval_i) begin
            v_d = 1'b0;
        end else if (load_i) begin
            v_d    = 1'b1;
            data_d = data_i;
        end else if (v_q & ready_i) begin
            v_d = 1'b0;
        end
    end

    // Valid bit is the only state that needs a reset value
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) v_q <= 1'b0;
        else            v_q <= v_d;
    end

    // Payload register, meaningful only while valid
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign data_o = data_q;
    assign v_o    = v_q;

endmodule

// File: rtl/bp_rolly_issue_ctrl.sv
// Consumer of the checkpointed (rolly) FIFO: reads speculatively into a
// one-entry output register, tracks uncommitted entries, and drives the FIFO
// commit/rewind/clear strobes. A flush is a rewind followed by a clear on the
// next cycle. Optional perf counters: define BP_ROLLY_ISSUE_PERF_EN.
module bp_rolly_issue_ctrl
    import bp_common_pkg::*;
#(
    parameter  int width_p        = 64,
    parameter  int inflight_max_p = 8,
    localparam int cnt_width_lp   = (inflight_max_p + 1 > 1) ? $clog2(inflight_max_p + 1) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [width_p-1:0]           fifo_data_i,
    input  logic                         fifo_v_i,
    output logic                         fifo_yumi_o,
    output logic                         fifo_deq_v_o,
    output logic                         fifo_roll_v_o,
    output logic                         fifo_clr_v_o,
    bp_rolly_issue_ctrl_if.master        issue_if,
    input  logic                         commit_v_i,
    input  logic                         roll_i,
    input  logic                         flush_i,
    output logic                         busy_o,
    output logic [cnt_width_lp-1:0]      inflight_o,
    output logic [perf_cnt_width_gp-1:0] roll_cnt_o,
    output logic [perf_cnt_width_gp-1:0] flush_cnt_o
);

    localparam logic [0:0]              state_run_lp = e_rolly_run;
    localparam logic [0:0]              state_clr_lp = e_rolly_flush_clr;
    localparam logic [cnt_width_lp-1:0] max_lp       = cnt_width_lp'(inflight_max_p);

    logic [0:0]              state_q, state_d;
    logic [cnt_width_lp-1:0] inflight_q, inflight_d;
    logic                    run, yumi, rewind;
    logic [width_p-1:0]      skid_data;
    logic                    skid_v;

    // Handshake and strobe decode; every strobe is forced low during reset
    always_comb begin
        run    = reset_n_i & (state_q == state_run_lp);
        yumi   = run & fifo_v_i & ~roll_i & ~flush_i
               & (~skid_v | issue_if.ready_i) & (inflight_q < max_lp);
        rewind = run & (roll_i | flush_i);
    end

    // FSM and in-flight counter next-state
    always_comb begin
        state_d    = state_q;
        inflight_d = inflight_q + cnt_width_lp'(yumi) - cnt_width_lp'(commit_v_i);
        if (rewind) begin
            inflight_d = '0;
        end
        if (run & flush_i) begin
            state_d = state_clr_lp;
        end else if (state_q == state_clr_lp) begin
            state_d = state_run_lp;
        end
    end

    // Control state registers
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= state_run_lp;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

    bp_rolly_issue_skid #(.width_p(width_p)) skid (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (yumi),
        .data_i    (fifo_data_i),
        .inval_i   (rewind),
        .ready_i   (issue_if.ready_i),
        .data_o    (skid_data),
        .v_o       (skid_v)
    );

    assign issue_if.data_o = skid_data;
    assign issue_if.v_o    = skid_v;
    assign fifo_yumi_o     = yumi;
    assign fifo_deq_v_o    = reset_n_i & commit_v_i;
    assign fifo_roll_v_o   = rewind;
    assign fifo_clr_v_o    = reset_n_i & (state_q == state_clr_lp);
    assign busy_o          = reset_n_i & (state_q == state_clr_lp);
    assign inflight_o      = inflight_q;

`ifdef BP_ROLLY_ISSUE_PERF_EN
    logic [perf_cnt_width_gp-1:0] roll_cnt_q, roll_cnt_d, flush_cnt_q, flush_cnt_d;

    // Saturating rewind/flush event counters
    always_comb begin
        roll_cnt_d  = roll_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (run & roll_i & ~flush_i & (roll_cnt_q != '1)) roll_cnt_d = roll_cnt_q + 32'd1;
        if (run & flush_i & (flush_cnt_q != '1))          flush_cnt_d = flush_cnt_q + 32'd1;
    end

    // Perf counter registers
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            roll_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            roll_cnt_q  <= roll_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign roll_cnt_o  = roll_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign roll_cnt_o  = '0;
    assign flush_cnt_o = '0;
`endif

    // A commit needs something in flight, and none may arrive mid-flush
    a_commit_needs_inflight: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        commit_v_i |-> (inflight_q != '0));
    a_no_commit_in_clr: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        commit_v_i |-> (state_q != state_clr_lp));

endmodule

// File: tb/tb_bp_rolly_issue_ctrl.sv
// Directed bench for bp_rolly_issue_ctrl with a small rolly-FIFO model.
module tb_bp_rolly_issue_ctrl;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [W-1:0] fifo_data;
    logic        fifo_v, fifo_yumi, fifo_deq, fifo_roll, fifo_clr;
    logic        commit_v = 1'b0, roll = 1'b0, flush = 1'b0;
    logic        busy;
    logic [1:0]  inflight;
    logic [31:0] roll_cnt, flush_cnt;

    bp_rolly_issue_ctrl_if #(.width_p(W)) issue_if ();

    bp_rolly_issue_ctrl #(.width_p(W), .inflight_max_p(2)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .fifo_data_i   (fifo_data),
        .fifo_v_i      (fifo_v),
        .fifo_yumi_o   (fifo_yumi),
        .fifo_deq_v_o  (fifo_deq),
        .fifo_roll_v_o (fifo_roll),
        .fifo_clr_v_o  (fifo_clr),
        .issue_if      (issue_if.master),
        .commit_v_i    (commit_v),
        .roll_i        (roll),
        .flush_i       (flush),
        .busy_o        (busy),
        .inflight_o    (inflight),
        .roll_cnt_o    (roll_cnt),
        .flush_cnt_o   (flush_cnt)
    );

    always #5 clk = ~clk;

    // Rolly FIFO model: read, commit and write pointers with rewind/clear
    logic         mdl_clr = 1'b0, push_v = 1'b0;
    logic [W-1:0] push_data = '0;
    logic [W-1:0] mem [0:15];
    logic [4:0]   rptr = '0, cptr = '0, wptr = '0, r_n, c_n, w_n;

    assign fifo_v    = (rptr != wptr);
    assign fifo_data = mem[rptr[3:0]];

    always_comb begin
        r_n = rptr; c_n = cptr; w_n = wptr;
        if (push_v)    w_n = wptr + 5'd1;
        if (fifo_yumi) r_n = rptr + 5'd1;
        if (fifo_deq)  c_n = cptr + 5'd1;
        if (fifo_roll) r_n = c_n;
        if (fifo_clr)  begin r_n = c_n; w_n = c_n; end
        if (mdl_clr)   begin r_n = '0; c_n = '0; w_n = '0; end
    end

    always @(posedge clk) begin
        rptr <= r_n; cptr <= c_n; wptr <= w_n;
        if (push_v) mem[wptr[3:0]] <= push_data;
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_roll_cnt, exp_flush_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        push_v = 1'b1; push_data = d;
        tick();
        push_v = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; mdl_clr = 1'b1;
        commit_v = 1'b0; roll = 1'b0; flush = 1'b0; issue_if.ready_i = 1'b1;
        tick(); tick();
        mdl_clr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        push(16'h1111);
        commit_v = 1'b1; roll = 1'b1; flush = 1'b1;
        #1;
        checks++; if (fifo_yumi !== 1'b0) begin errors++; $display("FAIL rst_yumi got %b want 0", fifo_yumi); end
        checks++; if (fifo_deq !== 1'b0) begin errors++; $display("FAIL rst_deq got %b want 0", fifo_deq); end
        checks++; if (fifo_roll !== 1'b0) begin errors++; $display("FAIL rst_roll got %b want 0", fifo_roll); end
        checks++; if (fifo_clr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_clr_busy got %b%b want 00", fifo_clr, busy); end
        checks++; if (issue_if.v_o !== 1'b0 || inflight !== 2'd0) begin errors++; $display("FAIL rst_state got v=%b inf=%0d want v=0 inf=0", issue_if.v_o, inflight); end
        checks++; if (roll_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d want 0/0", roll_cnt, flush_cnt); end
        commit_v = 1'b0; roll = 1'b0; flush = 1'b0;
    endtask

    task automatic test_streaming();
        do_reset();
        push(16'h00A1); push(16'h00B2); push(16'h00C3);
        reset_n = 1'b1; #1;
        checks++; if (fifo_yumi !== 1'b1 || issue_if.v_o !== 1'b0) begin errors++; $display("FAIL str_first got yumi=%b v=%b want 1 0", fifo_yumi, issue_if.v_o); end
        tick();
        checks++; if (issue_if.v_o !== 1'b1 || issue_if.data_o !== 16'h00A1) begin errors++; $display("FAIL str_A got v=%b d=%h want 1 00a1", issue_if.v_o, issue_if.data_o); end
        tick();
        checks++; if (issue_if.data_o !== 16'h00B2 || fifo_yumi !== 1'b0 || inflight !== 2'd2) begin errors++; $display("FAIL str_B got d=%h yumi=%b inf=%0d want 00b2 0 2", issue_if.data_o, fifo_yumi, inflight); end
        tick();
        checks++; if (issue_if.v_o !== 1'b0 || fifo_yumi !== 1'b0 || fifo_v !== 1'b1 || inflight !== 2'd2) begin errors++; $display("FAIL str_stall got v=%b yumi=%b fv=%b inf=%0d want 0 0 1 2", issue_if.v_o, fifo_yumi, fifo_v, inflight); end
        commit_v = 1'b1; #1;
        checks++; if (fifo_deq !== 1'b1 || fifo_yumi !== 1'b0) begin errors++; $display("FAIL str_commit got deq=%b yumi=%b want 1 0", fifo_deq, fifo_yumi); end
        tick(); commit_v = 1'b0; #1;
        checks++; if (inflight !== 2'd1 || fifo_yumi !== 1'b1) begin errors++; $display("FAIL str_resume got inf=%0d yumi=%b want 1 1", inflight, fifo_yumi); end
        tick();
        checks++; if (issue_if.v_o !== 1'b1 || issue_if.data_o !== 16'h00C3 || inflight !== 2'd2) begin errors++; $display("FAIL str_C got v=%b d=%h inf=%0d want 1 00c3 2", issue_if.v_o, issue_if.data_o, inflight); end
    endtask

    task automatic test_roll();
        do_reset();
        push(16'h00A1); push(16'h00B2);
        reset_n = 1'b1; #1;
        tick();
        checks++; if (issue_if.data_o !== 16'h00A1) begin errors++; $display("FAIL roll_A got %h want 00a1", issue_if.data_o); end
        tick();
        commit_v = 1'b1; roll = 1'b1; #1;
        checks++; if (fifo_deq !== 1'b1 || fifo_roll !== 1'b1 || fifo_yumi !== 1'b0 || fifo_clr !== 1'b0) begin errors++; $display("FAIL roll_pulse got deq=%b roll=%b yumi=%b clr=%b want 1 1 0 0", fifo_deq, fifo_roll, fifo_yumi, fifo_clr); end
        tick(); commit_v = 1'b0; roll = 1'b0; #1;
        checks++; if (issue_if.v_o !== 1'b0 || inflight !== 2'd0 || fifo_yumi !== 1'b1) begin errors++; $display("FAIL roll_after got v=%b inf=%0d yumi=%b want 0 0 1", issue_if.v_o, inflight, fifo_yumi); end
        tick();
        checks++; if (issue_if.v_o !== 1'b1 || issue_if.data_o !== 16'h00B2 || inflight !== 2'd1) begin errors++; $display("FAIL roll_replay got v=%b d=%h inf=%0d want 1 00b2 1", issue_if.v_o, issue_if.data_o, inflight); end
`ifdef BP_ROLLY_ISSUE_PERF_EN
        exp_roll_cnt = 32'd1;
`else
        exp_roll_cnt = 32'd0;
`endif
        checks++; if (roll_cnt !== exp_roll_cnt || flush_cnt !== 32'd0) begin errors++; $display("FAIL roll_cnt got %0d/%0d want %0d/0", roll_cnt, flush_cnt, exp_roll_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) push(16'hE000 + 16'(i));
        reset_n = 1'b1; #1;
        tick(); tick();
        checks++; if (inflight !== 2'd2 || issue_if.data_o !== 16'hE001) begin errors++; $display("FAIL fl_pre got inf=%0d d=%h want 2 e001", inflight, issue_if.data_o); end
        flush = 1'b1; #1;
        checks++; if (fifo_roll !== 1'b1 || fifo_clr !== 1'b0 || busy !== 1'b0 || fifo_yumi !== 1'b0) begin errors++; $display("FAIL fl_N got roll=%b clr=%b busy=%b yumi=%b want 1 0 0 0", fifo_roll, fifo_clr, busy, fifo_yumi); end
        tick(); flush = 1'b0; #1;
        checks++; if (fifo_clr !== 1'b1 || busy !== 1'b1 || fifo_roll !== 1'b0 || fifo_yumi !== 1'b0) begin errors++; $display("FAIL fl_N1 got clr=%b busy=%b roll=%b yumi=%b want 1 1 0 0", fifo_clr, busy, fifo_roll, fifo_yumi); end
        checks++; if (inflight !== 2'd0 || issue_if.v_o !== 1'b0) begin errors++; $display("FAIL fl_N1_state got inf=%0d v=%b want 0 0", inflight, issue_if.v_o); end
        tick();
        checks++; if (fifo_v !== 1'b0 || busy !== 1'b0 || fifo_clr !== 1'b0 || fifo_yumi !== 1'b0) begin errors++; $display("FAIL fl_done got fv=%b busy=%b clr=%b yumi=%b want 0 0 0 0", fifo_v, busy, fifo_clr, fifo_yumi); end
`ifdef BP_ROLLY_ISSUE_PERF_EN
        exp_flush_cnt = 32'd1;
`else
        exp_flush_cnt = 32'd0;
`endif
        checks++; if (flush_cnt !== exp_flush_cnt || roll_cnt !== 32'd0) begin errors++; $display("FAIL fl_cnt got %0d/%0d want %0d/0", flush_cnt, roll_cnt, exp_flush_cnt); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        push(16'h5A5A); push(16'h6B6B);
        reset_n = 1'b1; #1;
        tick();
        roll = 1'b1; flush = 1'b1; #1;
        checks++; if (fifo_roll !== 1'b1 || fifo_yumi !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sim_N got roll=%b yumi=%b busy=%b want 1 0 0", fifo_roll, fifo_yumi, busy); end
        tick();
        checks++; if (fifo_clr !== 1'b1 || fifo_roll !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL sim_clr got clr=%b roll=%b busy=%b want 1 0 1", fifo_clr, fifo_roll, busy); end
        tick(); roll = 1'b0; flush = 1'b0; #1;
        checks++; if (busy !== 1'b0 || fifo_v !== 1'b0) begin errors++; $display("FAIL sim_done got busy=%b fv=%b want 0 0", busy, fifo_v); end
`ifdef BP_ROLLY_ISSUE_PERF_EN
        exp_flush_cnt = 32'd1;
`else
        exp_flush_cnt = 32'd0;
`endif
        checks++; if (flush_cnt !== exp_flush_cnt || roll_cnt !== 32'd0) begin errors++; $display("FAIL sim_cnt got %0d/%0d want %0d/0", flush_cnt, roll_cnt, exp_flush_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        push(16'h00A1); push(16'h00B2);
        issue_if.ready_i = 1'b0;
        reset_n = 1'b1; #1;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                commit_v = 1'b1; #1;
                checks++; if (fifo_deq !== 1'b1) begin errors++; $display("FAIL bp_deq got %b want 1", fifo_deq); end
            end
            checks++; if (issue_if.v_o !== 1'b1 || issue_if.data_o !== 16'h00A1 || fifo_yumi !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got v=%b d=%h yumi=%b want 1 00a1 0", i, issue_if.v_o, issue_if.data_o, fifo_yumi); end
            tick();
            commit_v = 1'b0;
        end
        #1;
        checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL bp_inf got %0d want 0", inflight); end
        issue_if.ready_i = 1'b1; #1;
        checks++; if (fifo_yumi !== 1'b1) begin errors++; $display("FAIL bp_release got yumi=%b want 1", fifo_yumi); end
        tick();
        checks++; if (issue_if.data_o !== 16'h00B2 || inflight !== 2'd1) begin errors++; $display("FAIL bp_B got d=%h inf=%0d want 00b2 1", issue_if.data_o, inflight); end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        push(16'h0001); push(16'h0002); push(16'h0003);
        reset_n = 1'b1; #1;
        tick(); tick();
        flush = 1'b1; #1;
        tick(); flush = 1'b0; #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmf_busy got %b want 1", busy); end
        reset_n = 1'b0; #1;
        checks++; if (fifo_clr !== 1'b0 || busy !== 1'b0 || fifo_roll !== 1'b0 || fifo_yumi !== 1'b0) begin errors++; $display("FAIL rmf_strobes got clr=%b busy=%b roll=%b yumi=%b want 0 0 0 0", fifo_clr, busy, fifo_roll, fifo_yumi); end
        tick();
        reset_n = 1'b1; #1;
        checks++; if (issue_if.v_o !== 1'b0 || inflight !== 2'd0 || busy !== 1'b0 || fifo_clr !== 1'b0) begin errors++; $display("FAIL rmf_after got v=%b inf=%0d busy=%b clr=%b want 0 0 0 0", issue_if.v_o, inflight, busy, fifo_clr); end
        checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL rmf_cnt got %0d want 0", flush_cnt); end
    endtask

    initial begin
        issue_if.ready_i = 1'b1;
        test_reset();
        test_streaming();
        test_roll();
        test_flush();
        test_simultaneous();
        test_backpressure();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_rolly_issue_ctrl.md
Name: bp_rolly_issue_ctrl

Overview:
- Consumer stage directly downstream of the checkpointed (rolly) FIFO in the FE→BE command path.
- Reads entries speculatively into a 1-entry output register and presents them to the issue pipeline with a valid/ready handshake.
- Tracks read-but-uncommitted entries and drives the FIFO's commit (deq), rewind (roll) and clear (clr) controls.
- Flush is sequenced as a roll followed by a clr, because the FIFO cannot take both in the same cycle.

Parameters:
- width_p, 64: entry width in bits.
- inflight_max_p, 8: maximum number of read-but-uncommitted entries; must be ≤ the FIFO els_p and ≥ 1.
- cnt_width_lp (local): `BSG_SAFE_CLOG2(inflight_max_p+1).

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_n_i  in  1  synchronous reset, active-low.
- fifo_data_i  in  width_p  FIFO head data.
- fifo_v_i  in  1  FIFO head valid.
- fifo_yumi_o  out  1  read strobe to the FIFO.
- fifo_deq_v_o  out  1  commit strobe to the FIFO (advances its checkpoint).
- fifo_roll_v_o  out  1  rewind strobe to the FIFO.
- fifo_clr_v_o  out  1  clear strobe to the FIFO.
- data_o  out  width_p  entry presented to the issue pipeline.
- v_o  out  1  data_o valid.
- ready_i  in  1  issue pipeline accepts data_o when v_o & ready_i.
- commit_v_i  in  1  oldest in-flight entry retired.
- roll_i  in  1  rewind request: replay all uncommitted entries.
- flush_i  in  1  discard everything uncommitted and every unread entry.
- busy_o  out  1  high while in FLUSH_CLR.
- inflight_o  out  cnt_width_lp  current in-flight count.
- roll_cnt_o  out  32  perf counter (see Optional Feature).
- flush_cnt_o  out  32  perf counter (see Optional Feature).

Behaviour:
- Reset (reset_n_i=0 at posedge):
  - state=RUN, output register invalid, inflight=0, counters=0.
  - All strobe outputs are 0 while reset is asserted.
- Output register:
  - Loads fifo_data_i when fifo_yumi_o=1.
  - v_o cleared on handshake (v_o & ready_i) without a new load.
  - Read latency: FIFO head to data_o is 1 cycle.
- fifo_yumi_o = (state==RUN) & fifo_v_i & ~roll_i & ~flush_i & (~v_o | ready_i) & (inflight_r < inflight_max_p).
  - Commit in the same cycle does not bypass the throttle.
- inflight_next = inflight_r + yumi − commit_v_i, except on a roll or flush cycle, where it becomes 0.
  - Every entry read counts as in flight, including the one held in the output register.
- fifo_deq_v_o = commit_v_i, in every state except reset.
  - commit_v_i with inflight_r==0 is illegal; the assertion fires.
- Roll (roll_i=1, state RUN, flush_i=0):
  - fifo_roll_v_o=1 for one cycle; output register invalidated; no yumi.
  - The next cycle re-reads from the checkpoint.
- Flush (flush_i=1 in RUN; flush_i has priority over roll_i):
  - Cycle N: fifo_roll_v_o=1, output register invalidated, inflight→0, state→FLUSH_CLR.
  - Cycle N+1 (FLUSH_CLR): fifo_clr_v_o=1, yumi=0, busy_o=1, state→RUN.
  - Result: FIFO empty, with wptr=rptr=cptr.
- In FLUSH_CLR:
  - roll_i and flush_i are ignored.
  - commit_v_i is illegal; the assertion fires.
- Boundary cases:
  - inflight==max: yumi stalls until a commit arrives.
  - A consumer that holds ready_i low does not block commits.
  - A mid-operation reset returns to RUN immediately, with no residual strobes.

Optional Feature:
- Macro: BP_ROLLY_ISSUE_PERF_EN.
- Defined: roll_cnt_o increments on each roll_i-initiated rewind; flush_cnt_o increments on each flush_i acceptance. Both saturate at 2^32−1 and are zeroed by reset.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package (bp_common_pkg):
  - Typedef bp_rolly_issue_state_e {e_rolly_run, e_rolly_flush_clr}.
  - Constant for the perf counter width (32).
- Sub-module: bp_rolly_issue_skid, holding the 1-entry output register with v/ready and a synchronous invalidate input.

Test Plan:
- Streaming: FIFO holds A,B,C; ready_i=1, no commits, inflight_max_p=2 → data_o=A,B on consecutive cycles, then the yumi stall leaves C unread; inflight_o=2. One commit → C is read the next cycle.
- Roll: A,B read, A committed, roll_i pulse → fifo_deq_v_o and fifo_roll_v_o both high that cycle, v_o=0 next cycle; B re-presented 2 cycles after roll_i; inflight_o=0, then 1.
- Flush: 3 unread plus 2 in flight, flush_i pulse → roll_v_o at N, clr_v_o at N+1, busy_o at N+1 only; fifo_v_i=0 afterwards; inflight_o=0.
- Simultaneous: roll_i=1 and flush_i=1 → flush sequence taken (roll then clr); with the perf macro on, flush_cnt_o=1 and roll_cnt_o=0.
- Backpressure: ready_i=0 for 5 cycles with v_o=1 → data_o stable, no yumi; commit_v_i during the stall still pulses fifo_deq_v_o.
- Reset mid-flush: reset_n_i=0 during FLUSH_CLR → clr_v_o=0 and state=RUN; after release, v_o=0 and inflight_o=0.
